// File: rtl/dual_port_wb_regfile.sv
// rtl/dual_port_wb_regfile.sv - dual-issue RV32 integer register file, 2 write / 4 read ports
module dual_port_wb_regfile #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we0,
    input  logic [$clog2(NREG)-1:0] waddr0,
    input  logic [XLEN-1:0]         wdata0,
    input  logic                    we1,
    input  logic [$clog2(NREG)-1:0] waddr1,
    input  logic [XLEN-1:0]         wdata1,
    input  logic [$clog2(NREG)-1:0] raddr0,
    input  logic [$clog2(NREG)-1:0] raddr1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    input  logic [$clog2(NREG)-1:0] raddr3,
    output logic [XLEN-1:0]         rdata0,
    output logic [XLEN-1:0]         rdata1,
    output logic [XLEN-1:0]         rdata2,
    output logic [XLEN-1:0]         rdata3
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [AW-1:0]   raddr_v [4];
    logic [XLEN-1:0] rdata_v [4];

    // Slot 1 is applied after slot 0 so the younger instruction wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0 && (waddr0 != '0)) begin
                regs[waddr0] <= wdata0;
            end
            if (we1 && (waddr1 != '0)) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    assign raddr_v[0] = raddr0;
    assign raddr_v[1] = raddr1;
    assign raddr_v[2] = raddr2;
    assign raddr_v[3] = raddr3;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdata_v[p] = '0;
            if (rst || (raddr_v[p] == '0)) begin
                rdata_v[p] = '0;
            end else if (BYPASS && we1 && (waddr1 == raddr_v[p])) begin
                rdata_v[p] = wdata1;
            end else if (BYPASS && we0 && (waddr0 == raddr_v[p])) begin
                rdata_v[p] = wdata0;
            end else begin
                rdata_v[p] = regs[raddr_v[p]];
            end
        end
    end

    assign rdata0 = rdata_v[0];
    assign rdata1 = rdata_v[1];
    assign rdata2 = rdata_v[2];
    assign rdata3 = rdata_v[3];

endmodule

// File: tb/tb_dual_port_wb_regfile.sv
// tb/tb_dual_port_wb_regfile.sv - scoreboard bench for dual_port_wb_regfile, bypass on and off
module tb_dual_port_wb_regfile;
    logic        clk;
    logic        rst;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [4:0]  ra [4];
    logic [31:0] rd_b1 [4];
    logic [31:0] rd_b0 [4];

    logic [31:0] mdl [32];

    typedef struct {
        string       tag;
        int          dut;
        int          port;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dual_port_wb_regfile #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(ra[0]), .raddr1(ra[1]), .raddr2(ra[2]), .raddr3(ra[3]),
        .rdata0(rd_b1[0]), .rdata1(rd_b1[1]), .rdata2(rd_b1[2]), .rdata3(rd_b1[3])
    );

    dual_port_wb_regfile #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(ra[0]), .raddr1(ra[1]), .raddr2(ra[2]), .raddr3(ra[3]),
        .rdata0(rd_b0[0]), .rdata1(rd_b0[1]), .rdata2(rd_b0[2]), .rdata3(rd_b0[3])
    );

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
        if (rst) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (byp && we1 && (waddr1 == a)) return wdata1;
        if (byp && we0 && (waddr0 == a)) return wdata0;
        return mdl[a];
    endfunction

    task automatic step(input string tag, input bit r,
                        input bit w0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit w1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] r3);
        sb_t e;
        logic [31:0] obs;
        rst = r;
        we0 = w0; waddr0 = a0; wdata0 = d0;
        we1 = w1; waddr1 = a1; wdata1 = d1;
        ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
        for (int p = 0; p < 4; p++) begin
            sbq.push_back('{tag, 1, p, model_read(ra[p], 1'b1)});
            sbq.push_back('{tag, 0, p, model_read(ra[p], 1'b0)});
        end
        #2;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            obs = (e.dut == 1) ? rd_b1[e.port] : rd_b0[e.port];
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s bypass=%0d port=%0d raddr=%0d observed=%h expected=%h",
                       e.tag, e.dut, e.port, ra[e.port], obs, e.exp);
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else begin
            if (we0 && waddr0 != 5'd0) mdl[waddr0] = wdata0;
            if (we1 && waddr1 != 5'd0) mdl[waddr1] = wdata1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rst = 1'b1; we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        for (int p = 0; p < 4; p++) ra[p] = '0;
        @(negedge clk);

        step("reset_init", 1, 0, 0, 0, 0, 0, 0, 5, 1, 31, 0);
        // Test 1: reset discards a concurrent write and clears preloaded data
        step("preload_x5", 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 5, 5);
        step("x5_visible", 0, 0, 0, 0, 0, 0, 0, 5, 5, 5, 5);
        step("rst_with_wr", 1, 1, 5, 32'h1234, 0, 0, 0, 5, 5, 5, 5);
        step("after_rst", 0, 0, 0, 0, 0, 0, 0, 5, 5, 5, 5);
        // Test 2: dual write
        step("dual_wr", 0, 1, 3, 32'h11, 1, 4, 32'h22, 3, 4, 3, 4);
        step("dual_rd", 0, 0, 0, 0, 0, 0, 0, 3, 4, 4, 3);
        // Test 3: same-address collision, slot 1 wins
        step("collide", 0, 1, 7, 32'hAAAA0000, 1, 7, 32'h5555FFFF, 7, 7, 7, 7);
        step("collide_rd", 0, 0, 0, 0, 0, 0, 0, 7, 7, 7, 7);
        // Test 4: forwarding vs. array read
        step("preload_x9", 0, 1, 9, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        step("fwd_x9", 0, 1, 9, 32'h20, 0, 0, 0, 0, 0, 9, 0);
        step("fwd_x9_next", 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
        // Test 5: x0 guard
        step("x0_wr", 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0, 3, 4, 9);
        step("x0_next", 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 7);
        // Test 6: disabled write port neither stores nor forwards
        step("preload_x12", 0, 0, 0, 0, 1, 12, 32'h3, 0, 0, 0, 0);
        step("dis_wr", 0, 0, 0, 0, 0, 12, 32'h77, 12, 12, 12, 12);
        step("dis_next", 0, 0, 0, 0, 0, 0, 0, 12, 12, 12, 12);
        step("dis_wr0", 0, 0, 12, 32'h99, 1, 13, 32'h5, 12, 13, 12, 13);

        for (int n = 0; n < 60; n++) begin
            step("random", ($urandom_range(0, 15) == 0),
                 1'($urandom), 5'($urandom), $urandom,
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom));
        end
        step("final_rst", 1, 1, 3, 32'h1, 1, 4, 32'h2, 3, 4, 5, 7);
        step("final_rd", 0, 0, 0, 0, 0, 0, 0, 3, 4, 5, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
